// File: rtl/mux_scan_reg.sv
// mux_scan_reg: N-channel, W-bit registered selector. Captures one channel either on
// a manual request strobe or by round-robin auto-scan at a programmable divider rate,
// and presents the sample through a single-entry valid/ready output stage.
module mux_scan_reg #(
    parameter int W        = 2,
    parameter int N        = 4,
    parameter int SEL_W    = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   din,
    input  logic [SEL_W-1:0] sel,
    input  logic             mode,
    input  logic             req,
    input  logic             clr,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_ch,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf
);
    localparam int               DIV_W    = $clog2(SCAN_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N - 1);
    localparam logic [SEL_W-1:0] PTR_ONE  = SEL_W'(1);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_mode_q;
    logic [SEL_W-1:0]   r_ptr;
    logic [DIV_W-1:0]   r_div;
    logic [W-1:0]       r_data;
    logic [SEL_W-1:0]   r_ch;
    logic               r_err;
    logic               r_ovf;

    logic               w_mode_chg;
    logic               w_slot_free;
    logic               w_div_last;
    logic               w_man_evt;
    logic               w_scan_evt;
    logic               w_cap;
    logic               w_drop;
    logic [SEL_W-1:0]   w_idx;

    // An index outside the populated channels is flagged rather than read.
    function automatic logic idx_bad(input logic [SEL_W-1:0] idx);
        return ({1'b0, idx} >= (SEL_W + 1)'(N));
    endfunction

    // Channel extraction; indices >= N never touch din and yield zero.
    function automatic logic [W-1:0] pick(input logic [N*W-1:0] bus,
                                          input logic [SEL_W-1:0] idx);
        logic [W-1:0] v;
        v = '0;
        for (int c = 0; c < N; c++) begin
            if (idx == SEL_W'(c)) v = bus[c*W +: W];
        end
        return v;
    endfunction

    // Capture decision: a mode change suppresses capture on its own edge.
    always_comb begin
        w_mode_chg  = (mode != r_mode_q);
        w_slot_free = (r_state == ST_EMPTY) || out_ready;
        w_div_last  = (r_div == DIV_LAST);
        w_man_evt   = !mode && req && !w_mode_chg;
        w_scan_evt  = mode && !w_mode_chg && w_div_last;
        w_cap       = (w_man_evt || w_scan_evt) && w_slot_free;
        w_drop      = w_man_evt && !w_slot_free;
        w_idx       = mode ? r_ptr : sel;
    end

    // Scan pointer and divider; a blocked scan event freezes both until the slot frees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q <= 1'b0;
            r_ptr    <= '0;
            r_div    <= '0;
        end else begin
            r_mode_q <= mode;
            if (w_mode_chg) begin
                r_ptr <= '0;
                r_div <= '0;
            end else if (mode) begin
                if (!w_div_last) begin
                    r_div <= r_div + DIV_ONE;
                end else if (w_slot_free) begin
                    r_div <= '0;
                    r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_ONE;
                end
            end
        end
    end

    // Output stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // Output stage next state: a capture refills with no bubble, otherwise a handshake drains.
    always_comb begin
        w_state_nxt = r_state;
        if (w_cap)                                w_state_nxt = ST_FULL;
        else if (r_state == ST_FULL && out_ready) w_state_nxt = ST_EMPTY;
    end

    // Sample register: loads only on a capture, so fields hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_ch   <= '0;
            r_err  <= 1'b0;
        end else if (w_cap) begin
            r_data <= pick(din, w_idx);
            r_ch   <= w_idx;
            r_err  <= idx_bad(w_idx);
        end
    end

    // Sticky drop flag for manual requests; clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_ovf <= 1'b0;
        else if (clr)    r_ovf <= 1'b0;
        else if (w_drop) r_ovf <= 1'b1;
    end

    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign out_err   = r_err;
    assign out_valid = (r_state == ST_FULL);
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg: an N=4 and an N=3 instance share the same stimulus; a
// behavioural model predicts each capture and pushes it to a per-instance queue,
// and a monitor compares the presented sample and pops it on each handshake.
module tb_mux_scan_reg;
    localparam int W = 2, SEL_W = 2, SCAN_DIV = 4;
    localparam int NA = 4, NB = 3;
    localparam logic [7:0] DIN_REF = 8'b11_10_01_00;

    typedef struct packed {
        logic [1:0] data;
        logic [1:0] ch;
        logic       err;
    } smp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = DIN_REF;
    logic [1:0] sel = '0;
    logic       mode = 1'b0, req = 1'b0, clr = 1'b0, out_ready = 1'b0;

    logic [1:0] o_data  [2];
    logic [1:0] o_ch    [2];
    logic       o_err   [2];
    logic       o_valid [2];
    logic       o_ovf   [2];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    smp_t q0[$];
    smp_t q1[$];

    // behavioural model state (state after the upcoming edge)
    int   m_full [2];
    int   m_mode [2];
    int   m_pos  [2];
    int   m_ticks[2];
    int   m_ovf  [2];
    bit   pend   [2];
    smp_t pend_s [2];
    // model state committed at the last edge, used by the monitor
    int   c_full [2];
    int   c_ovf  [2];

    always #5 clk = ~clk;

    mux_scan_reg #(.W(W), .N(NA), .SEL_W(SEL_W), .SCAN_DIV(SCAN_DIV)) u_a (
        .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode), .req(req), .clr(clr),
        .out_data(o_data[0]), .out_ch(o_ch[0]), .out_err(o_err[0]), .out_valid(o_valid[0]),
        .out_ready(out_ready), .ovf(o_ovf[0]));

    mux_scan_reg #(.W(W), .N(NB), .SEL_W(SEL_W), .SCAN_DIV(SCAN_DIV)) u_b (
        .clk(clk), .rst_n(rst_n), .din(din[5:0]), .sel(sel), .mode(mode), .req(req), .clr(clr),
        .out_data(o_data[1]), .out_ch(o_ch[1]), .out_err(o_err[1]), .out_valid(o_valid[1]),
        .out_ready(out_ready), .ovf(o_ovf[1]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0; m_mode[i] = 0; m_pos[i] = 0; m_ticks[i] = 0; m_ovf[i] = 0;
            pend[i] = 1'b0; c_full[i] = 0; c_ovf[i] = 0;
        end
        q0.delete();
        q1.delete();
    endfunction

    // Predict what instance i does at the next edge with the inputs now applied.
    function automatic void model_cycle(input int i);
        int n;
        bit free, cap, drop;
        int idx;
        n    = (i == 0) ? NA : NB;
        free = (m_full[i] == 0) || out_ready;
        cap  = 1'b0;
        drop = 1'b0;
        idx  = 0;
        if (int'(mode) != m_mode[i]) begin
            m_mode[i]  = int'(mode);
            m_pos[i]   = 0;
            m_ticks[i] = 0;
        end else if (mode) begin
            if (m_ticks[i] >= SCAN_DIV - 1) begin
                if (free) begin
                    cap        = 1'b1;
                    idx        = m_pos[i];
                    m_pos[i]   = (m_pos[i] + 1) % n;
                    m_ticks[i] = 0;
                end
            end else begin
                m_ticks[i]++;
            end
        end else if (req) begin
            if (free) begin
                cap = 1'b1;
                idx = int'(sel);
            end else begin
                drop = 1'b1;
            end
        end
        if (clr)       m_ovf[i] = 0;
        else if (drop) m_ovf[i] = 1;
        if (cap) begin
            m_full[i]      = 1;
            pend[i]        = 1'b1;
            pend_s[i].ch   = 2'(idx);
            pend_s[i].err  = (idx >= n);
            pend_s[i].data = (idx < n) ? 2'(din >> (W * idx)) : 2'b00;
        end else if (out_ready) begin
            m_full[i] = 0;
        end
    endfunction

    // One clock: commit last prediction at the edge, then apply new inputs.
    task automatic step(input logic md, input logic [1:0] s, input logic rq,
                        input logic cl, input logic rd, input logic [7:0] d);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (pend[i]) begin
                if (i == 0) q0.push_back(pend_s[i]);
                else        q1.push_back(pend_s[i]);
            end
            pend[i]   = 1'b0;
            c_full[i] = m_full[i];
            c_ovf[i]  = m_ovf[i];
        end
        #1;
        mode = md; sel = s; req = rq; clr = cl; out_ready = rd; din = d;
        for (int i = 0; i < 2; i++) model_cycle(i);
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_data%0d", tag, i),  o_data[i],  0);
            chk($sformatf("%s_ch%0d", tag, i),    o_ch[i],    0);
            chk($sformatf("%s_err%0d", tag, i),   o_err[i],   0);
            chk($sformatf("%s_valid%0d", tag, i), o_valid[i], 0);
            chk($sformatf("%s_ovf%0d", tag, i),   o_ovf[i],   0);
        end
    endtask

    // Asynchronous reset mid-cycle; the model restarts from the reset state.
    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("rst_async");
        model_clear();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) model_cycle(i);
    endtask

    // Monitor: compare the presented sample against the queue head; pop on handshake.
    initial begin
        smp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("valid%0d", i), o_valid[i], c_full[i]);
                    chk($sformatf("ovf%0d", i),   o_ovf[i],   c_ovf[i]);
                    if (o_valid[i] && ((i == 0) ? q0.size() : q1.size()) > 0) begin
                        e = (i == 0) ? q0[0] : q1[0];
                        chk($sformatf("data%0d", i), o_data[i], e.data);
                        chk($sformatf("ch%0d", i),   o_ch[i],   e.ch);
                        chk($sformatf("err%0d", i),  o_err[i],  e.err);
                        if (out_ready) begin
                            if (i == 0) void'(q0.pop_front());
                            else        void'(q1.pop_front());
                        end
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic md;
        model_clear();
        #2 check_zero("rst_init");
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) model_cycle(i);
        mon_en = 1'b1;

        // manual single request, then idle
        step(1'b0, 2'd2, 1'b1, 1'b0, 1'b1, DIN_REF);
        repeat (3) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, DIN_REF);
        // out-of-range index (flagged on the N=3 instance)
        step(1'b0, 2'd3, 1'b1, 1'b0, 1'b1, DIN_REF);
        repeat (2) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, DIN_REF);
        // backpressure: second request dropped, ovf sticky until clr
        step(1'b0, 2'd1, 1'b1, 1'b0, 1'b0, DIN_REF);
        step(1'b0, 2'd3, 1'b1, 1'b0, 1'b0, DIN_REF);
        repeat (3) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, DIN_REF);
        repeat (2) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, DIN_REF);
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, DIN_REF);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, DIN_REF);
        // scan, free running
        repeat (22) step(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, DIN_REF);
        // scan stall, then release
        repeat (10) step(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, DIN_REF);
        repeat (12) step(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, DIN_REF);
        // reset mid-scan while holding a sample, then scan resumes
        repeat (3) step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, DIN_REF);
        do_reset();
        repeat (12) step(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, DIN_REF);

        // randomized traffic
        md = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 63) == 0) md = ~md;
            step(md, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
                 8'($urandom));
            if (k == 1500) do_reset();
        end
        repeat (3) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, DIN_REF);
        @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
